// File: rtl/vp_pkg.sv
// Shared widths and the EX/MEM payload layout for the vector processor pipeline.
package vp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned VEC_W  = 128;
    localparam int unsigned REG_W  = 4;

    // One EX/MEM instruction slot; control bits first so a cleared slot is a NOP.
    typedef struct packed {
        logic              regw;
        logic              memw;
        logic              regmem;
        logic [REG_W-1:0]  reg_scr;
        logic [DATA_W-1:0] alu_rslt;
        logic [DATA_W-1:0] address;
        logic [VEC_W-1:0]  regrslt_v;
    } ex_mem_t;

    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

endpackage : vp_pkg

// File: rtl/pipe_reg.sv
// Generic pipeline register: WIDTH flops, asynchronous active-high clear to 0.
module pipe_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Capture every rising edge; reset clears immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : pipe_reg

// File: rtl/em_pipe.sv
// EX/MEM pipeline register: all execute-stage fields delayed by one clock.
module em_pipe #(
    parameter int unsigned DATA_W = vp_pkg::DATA_W,
    parameter int unsigned VEC_W  = vp_pkg::VEC_W,
    parameter int unsigned REG_W  = vp_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regw_E,
    input  logic              memw_E,
    input  logic              regmem_E,
    input  logic [REG_W-1:0]  regScr_E,
    input  logic [DATA_W-1:0] ALUrslt_E,
    input  logic [DATA_W-1:0] address_E,
    input  logic [VEC_W-1:0]  regrsltV_E,
    output logic              regw_M,
    output logic              memw_M,
    output logic              regmem_M,
    output logic [REG_W-1:0]  regScr_M,
    output logic [DATA_W-1:0] ALUrslt_M,
    output logic [DATA_W-1:0] address_M,
    output logic [VEC_W-1:0]  regrsltV_M
);

    localparam int unsigned BUS_W = 3 + REG_W + DATA_W + DATA_W + VEC_W;

    logic [BUS_W-1:0] em_d;
    logic [BUS_W-1:0] em_q;

    // Single shared register so control and data always clear together.
    assign em_d = {regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E, regrsltV_E};

    pipe_reg #(
        .WIDTH (BUS_W)
    ) u_em_reg (
        .clk (clk),
        .rst (rst),
        .d_i (em_d),
        .q_o (em_q)
    );

    assign {regw_M, memw_M, regmem_M, regScr_M, ALUrslt_M, address_M, regrsltV_M} = em_q;

endmodule : em_pipe

// File: tb/tb_em_pipe.sv
// Self-checking bench for em_pipe: directed scenarios then randomized traffic.
module tb_em_pipe;

    typedef struct packed {
        logic         regw;
        logic         memw;
        logic         regmem;
        logic [3:0]   scr;
        logic [31:0]  alu;
        logic [31:0]  addr;
        logic [127:0] vec;
    } fields_t;

    logic         clk;
    logic         rst;
    logic         regw_E, memw_E, regmem_E;
    logic [3:0]   regScr_E;
    logic [31:0]  ALUrslt_E, address_E;
    logic [127:0] regrsltV_E;
    logic         regw_M, memw_M, regmem_M;
    logic [3:0]   regScr_M;
    logic [31:0]  ALUrslt_M, address_M;
    logic [127:0] regrsltV_M;

    int checks = 0;
    int errors = 0;

    em_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .regw_E     (regw_E),
        .memw_E     (memw_E),
        .regmem_E   (regmem_E),
        .regScr_E   (regScr_E),
        .ALUrslt_E  (ALUrslt_E),
        .address_E  (address_E),
        .regrsltV_E (regrsltV_E),
        .regw_M     (regw_M),
        .memw_M     (memw_M),
        .regmem_M   (regmem_M),
        .regScr_M   (regScr_M),
        .ALUrslt_M  (ALUrslt_M),
        .address_M  (address_M),
        .regrsltV_M (regrsltV_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input fields_t f);
        regw_E     = f.regw;
        memw_E     = f.memw;
        regmem_E   = f.regmem;
        regScr_E   = f.scr;
        ALUrslt_E  = f.alu;
        address_E  = f.addr;
        regrsltV_E = f.vec;
    endtask

    function automatic fields_t observed();
        fields_t o;
        o.regw   = regw_M;
        o.memw   = memw_M;
        o.regmem = regmem_M;
        o.scr    = regScr_M;
        o.alu    = ALUrslt_M;
        o.addr   = address_M;
        o.vec    = regrsltV_M;
        return o;
    endfunction

    function automatic fields_t rand_fields();
        fields_t r;
        r.regw   = 1'($urandom);
        r.memw   = 1'($urandom);
        r.regmem = 1'($urandom);
        r.scr    = 4'($urandom);
        r.alu    = 32'($urandom);
        r.addr   = 32'($urandom);
        r.vec    = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        return r;
    endfunction

    task automatic check(input string tag, input fields_t exp);
        fields_t obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [127:0] exp);
        checks++;
        assert (regrsltV_M === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, regrsltV_M, exp);
        end
    endtask

    // Reference model: _M shows the _E value present at the last rising edge
    // taken with rst low, and shows all zeros whenever reset has intervened since.
    fields_t model;
    fields_t zero_f;
    fields_t f;
    fields_t prev;

    initial begin
        zero_f = '0;

        // Reset with nonzero inputs: outputs clear before any clock edge.
        f = '0;
        f.regw = 1'b1;
        f.alu  = 32'hDEADBEEF;
        apply(f);
        rst = 1'b1;
        #1;
        check("reset_async", zero_f);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", zero_f);
        model = zero_f;

        // Single capture, driven mid-cycle after release.
        @(negedge clk);
        rst = 1'b0;
        f = '0;
        f.regw = 1'b1;
        f.scr  = 4'b0011;
        f.alu  = 32'h0000FFFF;
        f.addr = 32'h00010004;
        apply(f);
        #1;
        check("single_before_edge", model);
        @(posedge clk);
        model = f;
        #1;
        check("single_capture", model);

        // Back-to-back capture without a bubble.
        @(negedge clk);
        f.scr  = 4'b0100;
        f.addr = 32'h00000000;
        apply(f);
        @(posedge clk);
        model = f;
        #1;
        check("back_to_back", model);
        checks++;
        assert (regw_M === 1'b1 && regScr_M === 4'b0100 && address_M === 32'h0)
        else begin
            errors++;
            $error("FAIL b2b_fields observed=%b/%h/%h expected=1/4/0", regw_M, regScr_M, address_M);
        end

        // Vector width: both patterns through with one-cycle latency.
        @(negedge clk);
        f.vec = 128'h0123456789ABCDEF_FEDCBA9876543210;
        apply(f);
        @(posedge clk);
        #1;
        check_vec("vec_pattern", 128'h0123456789ABCDEF_FEDCBA9876543210);
        @(negedge clk);
        f.vec = '1;
        apply(f);
        #1;
        check_vec("vec_hold", 128'h0123456789ABCDEF_FEDCBA9876543210);
        @(posedge clk);
        model = f;
        #1;
        check_vec("vec_ones", '1);

        // Mid-operation reset pulse shorter than a period.
        @(negedge clk);
        f.memw = 1'b1;
        f.addr = 32'h00010004;
        apply(f);
        @(posedge clk);
        model = f;
        #1;
        check("preload_memw", model);
        #1;
        rst = 1'b1;
        #1;
        model = zero_f;
        check("midop_reset_now", model);
        #2;
        rst = 1'b0;
        #1;
        check("midop_reset_held", model);
        f = rand_fields();
        apply(f);
        @(posedge clk);
        model = f;
        #1;
        check("after_release", model);

        // Glitch immunity: only the value at the edge may be captured.
        @(negedge clk);
        prev = model;
        for (int i = 0; i < 4; i++) begin
            apply(rand_fields());
            #1;
        end
        check("glitch_no_effect", prev);
        f = rand_fields();
        apply(f);
        @(posedge clk);
        model = f;
        #1;
        check("glitch_capture", model);

        // Reset coinciding with a clock edge: reset wins.
        @(negedge clk);
        apply(rand_fields());
        @(posedge clk);
        rst = 1'b1;
        #1;
        model = zero_f;
        check("reset_at_edge", model);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with occasional short reset pulses.
        for (int n = 0; n < 60; n++) begin
            f = rand_fields();
            apply(f);
            @(posedge clk);
            model = f;
            #1;
            check("rand_capture", model);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                #1;
                model = zero_f;
                check("rand_reset", model);
                rst = 1'b0;
            end
            @(negedge clk);
            apply(rand_fields());
            #1;
            check("rand_hold", model);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_em_pipe

// File: doc/em_pipe.md
# em_pipe

EX/MEM pipeline register of the vector processor. It samples the execute-stage control bits, scalar ALU result, memory address, destination register and 128-bit vector result on every rising clock edge. It presents these values unchanged to the memory stage one cycle later. The block contains no logic on the data path: no stall, no flush and no bypass.

## Interface
Parameters:
- DATA_W, 32: scalar ALU result and address width.
- VEC_W, 128: vector result width (4 lanes × 32 bit).
- REG_W, 4: destination register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- regw_E  in  1  register-file write enable from EX.
- memw_E  in  1  data-memory write enable from EX.
- regmem_E  in  1  writeback select from EX: 1 = memory data, 0 = ALU result.
- regScr_E  in  REG_W  destination register index from EX.
- ALUrslt_E  in  DATA_W  scalar ALU result from EX.
- address_E  in  DATA_W  memory address from EX.
- regrsltV_E  in  VEC_W  vector ALU result from EX.
- regw_M  out  1  registered regw_E.
- memw_M  out  1  registered memw_E.
- regmem_M  out  1  registered regmem_E.
- regScr_M  out  REG_W  registered regScr_E.
- ALUrslt_M  out  DATA_W  registered ALUrslt_E.
- address_M  out  DATA_W  registered address_E.
- regrsltV_M  out  VEC_W  registered regrsltV_E.

## Operation
- Each _M output is a flop driven by the matching _E input. There is no enable, so every field is captured on every rising clk edge.
- No transformation is applied: bit widths match one-to-one, with no sign extension, truncation or gating.
- Reset: while rst = 1, all outputs are forced to 0 immediately, independent of clk. In reset state, regw_M = memw_M = regmem_M = 0 and regScr_M = 0, ALUrslt_M = 0, address_M = 0, regrsltV_M = 0. This yields a NOP (no register or memory write) into MEM.
- Reset deassertion: the first rising edge with rst = 0 captures the current _E values.
- Reset asserted mid-operation clears all fields at once. The in-flight instruction is discarded.
- Control bits and data fields share the same reset, so a partially cleared state never occurs.
- No state machine and no handshake.

## Timing
- Latency: exactly 1 clk cycle from _E to _M.
- Outputs change only on the rising clk edge or on rst assertion.
- Input changes between edges have no effect on the outputs.
- Back-to-back instructions are captured on consecutive edges with no bubble.
- Outputs are registered, so there is no combinational path from input to output.
- If rst and a clk edge coincide, reset wins and the outputs are 0.

## Structure
- Shared package (vp_pkg): DATA_W = 32, VEC_W = 128, REG_W = 4. Optionally, a packed struct ex_mem_t grouping the seven fields, reused by the EX and MEM stages.
- One natural sub-module, pipe_reg:
  - Parameterized WIDTH with asynchronous active-high reset to 0.
  - em_pipe instantiates it once per field, or once over the concatenated 1+1+1+REG_W+DATA_W+DATA_W+VEC_W = 199-bit bus.
- The same pipe_reg is reused by the IF/ID, ID/EX and MEM/WB registers.

## Test plan
- Reset: drive rst = 1 with nonzero inputs (ALUrslt_E = 32'hDEADBEEF, regw_E = 1). All outputs must read 0 asynchronously, before any clk edge, and stay 0 across edges while rst = 1.
- Single capture:
  - Stimulus: after reset release, drive regw_E = 1, memw_E = 0, regmem_E = 0, regScr_E = 4'b0011, ALUrslt_E = 32'h0000FFFF, address_E = 32'h00010004, regrsltV_E = 0, mid-cycle.
  - Required response: after the next rising edge, the _M outputs equal exactly these values; before that edge, the previous values are held.
- Back-to-back:
  - Stimulus: on the following cycle, drive regScr_E = 4'b0100, ALUrslt_E = 32'h0000FFFF, address_E = 32'h00000000.
  - Required response: after the next edge, regScr_M = 4'b0100 and address_M = 0, with regw_M still 1.
- Vector width: drive regrsltV_E = 128'h0123456789ABCDEF_FEDCBA9876543210, then 128'hFFFF…FF. regrsltV_M must track it with 1-cycle latency and all 128 bits intact.
- Mid-operation reset: while memw_M = 1 and address_M = 32'h00010004, pulse rst for less than a clk period between edges. Outputs must drop to 0 immediately, and the next edge after release must capture the current _E values.
- Glitch immunity: toggle all _E inputs several times between two rising edges. Only the values present at the edge may appear on _M.
